// File: rtl/mdu_divider_if.sv
// Handshake and operand/result bundle for the multi-cycle MDU divider.
// The requester drives the master side; the divider drives the slave side.
interface mdu_divider_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, is_signed, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, is_signed, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/mdu_divider.sv
// Restoring signed/unsigned divider, one quotient bit per clock (DIV/DIVU -> LO/HI).
// Optional MDU_DIV_ZERO_FAST_EN: a zero divisor skips the iterations and finishes in two edges.
module mdu_divider #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic clk,
  input  logic rst,
  mdu_divider_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] counter;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH-1:0] dvd_raw;
  logic             q_neg;
  logic             r_neg;
  logic             dbz;

  logic [WIDTH-1:0] dvd_mag_in;
  logic [WIDTH-1:0] dvs_mag_in;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   trial;
  logic             divisor_zero;

  assign dvd_mag_in   = (bus.is_signed && bus.dividend[WIDTH-1]) ? -bus.dividend : bus.dividend;
  assign dvs_mag_in   = (bus.is_signed && bus.divisor[WIDTH-1])  ? -bus.divisor  : bus.divisor;
  assign divisor_zero = (bus.divisor == '0);

  // The extra top bit of the trial subtraction acts as the borrow/sign.
  assign rem_sh = {rem, quo[WIDTH-1]};
  assign trial  = rem_sh - {1'b0, dvs_mag};

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      counter         <= '0;
      rem             <= '0;
      quo             <= '0;
      dvs_mag         <= '0;
      dvd_raw         <= '0;
      q_neg           <= 1'b0;
      r_neg           <= 1'b0;
      dbz             <= 1'b0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.quotient    <= '0;
      bus.remainder   <= '0;
      bus.div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            rem      <= '0;
            quo      <= dvd_mag_in;
            dvs_mag  <= dvs_mag_in;
            dvd_raw  <= bus.dividend;
            q_neg    <= bus.is_signed & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
            r_neg    <= bus.is_signed & bus.dividend[WIDTH-1];
            dbz      <= divisor_zero;
            counter  <= '0;
            bus.busy <= 1'b1;
`ifdef MDU_DIV_ZERO_FAST_EN
            state    <= divisor_zero ? FIX : RUN;
`else
            state    <= RUN;
`endif
          end else begin
            state <= IDLE;
          end
        end

        RUN: begin
          if (!trial[WIDTH]) begin
            rem <= trial[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b1};
          end else begin
            rem <= rem_sh[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b0};
          end
          counter <= counter + CNT_W'(1);
          if (counter == CNT_W'(WIDTH - 1)) begin
            state <= FIX;
          end
        end

        FIX: begin
          // A zero divisor reports all-ones and the raw dividend regardless of signedness.
          if (dbz) begin
            bus.quotient  <= '1;
            bus.remainder <= dvd_raw;
          end else begin
            bus.quotient  <= q_neg ? -quo : quo;
            bus.remainder <= r_neg ? -rem : rem;
          end
          bus.div_by_zero <= dbz;
          bus.busy        <= 1'b0;
          bus.done        <= 1'b1;
          state           <= DONE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_divider.sv
// Directed, table-driven bench for mdu_divider (WIDTH=32) with hand-computed results,
// plus hand-written sequences for ignored start, back-to-back start and mid-operation reset.
module tb_mdu_divider;

  localparam int WIDTH   = 32;
  localparam int FULL_LAT = WIDTH + 1;
`ifdef MDU_DIV_ZERO_FAST_EN
  localparam int DBZ_LAT = 1;
`else
  localparam int DBZ_LAT = WIDTH + 1;
`endif
  localparam int TIMEOUT = 200;

  typedef struct {
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] exp_q;
    logic [31:0] exp_r;
    logic        exp_dbz;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  mdu_divider_if #(.WIDTH(WIDTH)) bus ();

  mdu_divider #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Counts edges from the current point until done is seen, sampling 1 time unit after each edge.
  task automatic waitDone(input int lat_in, output int lat, output int busy_cycles);
    lat = lat_in;
    busy_cycles = 0;
    while (!bus.done && lat < TIMEOUT) begin
      if (bus.busy) busy_cycles++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // Drives one start pulse; returns once the edge E0 has accepted it.
  task automatic applyStimulus(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.is_signed = sgn;
    bus.dividend  = a;
    bus.divisor   = b;
    bus.start     = 1'b1;
    @(posedge clk); #1;
    bus.start     = 1'b0;
  endtask

  vec_t vecs[13];

  initial begin
    int lat;
    int bc;
    int pulses;
    logic [31:0] held_q;

    vecs[0]  = '{1'b0, 32'd100,       32'd7,         32'd14,        32'd2,         1'b0};
    vecs[1]  = '{1'b1, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD,  32'hFFFFFFFF,  1'b0};
    vecs[2]  = '{1'b1, 32'd7,         32'hFFFFFFFE,  32'hFFFFFFFD,  32'd1,         1'b0};
    vecs[3]  = '{1'b1, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  32'd0,         1'b0};
    vecs[4]  = '{1'b0, 32'h80000000,  32'hFFFFFFFF,  32'd0,         32'h80000000,  1'b0};
    vecs[5]  = '{1'b1, 32'd5,         32'd0,         32'hFFFFFFFF,  32'd5,         1'b1};
    vecs[6]  = '{1'b0, 32'hFFFFFFFF,  32'd0,         32'hFFFFFFFF,  32'hFFFFFFFF,  1'b1};
    vecs[7]  = '{1'b1, 32'hFFFFFFF9,  32'd0,         32'hFFFFFFFF,  32'hFFFFFFF9,  1'b1};
    vecs[8]  = '{1'b0, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'd1,         32'd0,         1'b0};
    vecs[9]  = '{1'b1, 32'hFFFFFFF9,  32'hFFFFFFFE,  32'd3,         32'hFFFFFFFF,  1'b0};
    vecs[10] = '{1'b0, 32'hFFFFFFF9,  32'd2,         32'h7FFFFFFC,  32'd1,         1'b0};
    vecs[11] = '{1'b0, 32'd3,         32'd5,         32'd0,         32'd3,         1'b0};
    vecs[12] = '{1'b1, 32'hFFFFFF9C,  32'd7,         32'hFFFFFFF2,  32'hFFFFFFFE,  1'b0};

    bus.start     = 1'b0;
    bus.is_signed = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_busy", 32'(bus.busy), 32'd0);
    checkOutput("reset_done", 32'(bus.done), 32'd0);
    checkOutput("reset_quotient", bus.quotient, 32'd0);
    checkOutput("reset_remainder", bus.remainder, 32'd0);
    checkOutput("reset_dbz", 32'(bus.div_by_zero), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].is_signed, vecs[i].dividend, vecs[i].divisor);
      waitDone(0, lat, bc);
      checkOutput($sformatf("v%0d_quotient", i), bus.quotient, vecs[i].exp_q);
      checkOutput($sformatf("v%0d_remainder", i), bus.remainder, vecs[i].exp_r);
      checkOutput($sformatf("v%0d_dbz", i), 32'(bus.div_by_zero), 32'(vecs[i].exp_dbz));
      checkOutput($sformatf("v%0d_latency", i), lat, vecs[i].exp_dbz ? DBZ_LAT : FULL_LAT);
      checkOutput($sformatf("v%0d_busy_cycles", i), bc, vecs[i].exp_dbz ? DBZ_LAT : FULL_LAT);
      checkOutput($sformatf("v%0d_busy_in_done", i), 32'(bus.busy), 32'd0);
      @(posedge clk); #1;
      checkOutput($sformatf("v%0d_done_one_cycle", i), 32'(bus.done), 32'd0);
    end

    // Start pulsed while busy is ignored; earlier results stay visible during RUN.
    held_q = bus.quotient;
    applyStimulus(1'b0, 32'd100, 32'd7);
    repeat (4) @(posedge clk);
    @(negedge clk);
    bus.dividend = 32'd9;
    bus.divisor  = 32'd3;
    bus.start    = 1'b1;
    @(posedge clk); #1;
    bus.start    = 1'b0;
    checkOutput("ignored_busy", 32'(bus.busy), 32'd1);
    checkOutput("ignored_held_quotient", bus.quotient, held_q);
    waitDone(5, lat, bc);
    checkOutput("ignored_latency", lat, FULL_LAT);
    checkOutput("ignored_quotient", bus.quotient, 32'd14);
    checkOutput("ignored_remainder", bus.remainder, 32'd2);

    // Back-to-back: start driven during the DONE cycle is accepted at the next edge.
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    checkOutput("b2b_done_drops", 32'(bus.done), 32'd0);
    checkOutput("b2b_busy", 32'(bus.busy), 32'd1);
    waitDone(0, lat, bc);
    checkOutput("b2b_latency", lat, FULL_LAT);
    checkOutput("b2b_quotient", bus.quotient, 32'd3);
    checkOutput("b2b_remainder", bus.remainder, 32'd0);

    // Reset at E0+10 aborts with no done pulse.
    applyStimulus(1'b0, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("abort_busy", 32'(bus.busy), 32'd0);
    checkOutput("abort_done", 32'(bus.done), 32'd0);
    checkOutput("abort_quotient", bus.quotient, 32'd0);
    checkOutput("abort_remainder", bus.remainder, 32'd0);
    checkOutput("abort_dbz", 32'(bus.div_by_zero), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (bus.done) pulses++;
    end
    checkOutput("abort_no_done", pulses, 32'd0);
    applyStimulus(1'b1, 32'd9, 32'd3);
    waitDone(0, lat, bc);
    checkOutput("after_abort_latency", lat, FULL_LAT);
    checkOutput("after_abort_quotient", bus.quotient, 32'd3);
    checkOutput("after_abort_remainder", bus.remainder, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
